// File: rtl/sram_arb_pkg.sv
// Shared types and default sizes for the four-core SRAM arbiter.
// Latency: n/a (declarations only). Backpressure: n/a.
// Default sizes match a 1Mx16 SRAM shared by four cores.
package sram_arb_pkg;

    localparam int NUM_CPU_DEF = 4;
    localparam int ADDR_W_DEF  = 20;
    localparam int DATA_W_DEF  = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/sram_arbiter_if.sv
// Core-request and SRAM-side bus bundle for sram_arbiter.
// Latency: n/a (wires only). Backpressure: cores hold cpu_CE low until memReady.
// master = arbiter side, slave = cores plus SRAM side.
interface sram_arbiter_if #(
    parameter int NUM_CPU = sram_arb_pkg::NUM_CPU_DEF,
    parameter int ADDR_W  = sram_arb_pkg::ADDR_W_DEF,
    parameter int DATA_W  = sram_arb_pkg::DATA_W_DEF
);
    logic [NUM_CPU-1:0]        cpu_CE;
    logic [NUM_CPU-1:0]        cpu_WE;
    logic [NUM_CPU*ADDR_W-1:0] cpu_ADDR;
    logic [NUM_CPU*DATA_W-1:0] cpu_wdata;
    logic [NUM_CPU-1:0]        memReady;
    logic [DATA_W-1:0]         Data_from_SRAM_cpu;
    logic [NUM_CPU-1:0]        grant;
    logic                      CE;
    logic                      UB;
    logic                      LB;
    logic                      OE;
    logic                      WE;
    logic [ADDR_W-1:0]         ADDR;
    logic [DATA_W-1:0]         Data_to_SRAM;
    logic [DATA_W-1:0]         Data_from_SRAM;
    logic [NUM_CPU*16-1:0]     grant_count;

    modport master (
        input  cpu_CE, cpu_WE, cpu_ADDR, cpu_wdata, Data_from_SRAM,
        output memReady, Data_from_SRAM_cpu, grant,
        output CE, UB, LB, OE, WE, ADDR, Data_to_SRAM, grant_count
    );

    modport slave (
        output cpu_CE, cpu_WE, cpu_ADDR, cpu_wdata, Data_from_SRAM,
        input  memReady, Data_from_SRAM_cpu, grant,
        input  CE, UB, LB, OE, WE, ADDR, Data_to_SRAM, grant_count
    );

endinterface

// File: rtl/sram_arbiter_rr_pick.sv
// Round-robin selector: first requester at or after ptr, wrapping.
// Latency: combinational. Backpressure: none, pure function of req/ptr.
module rr_pick #(
    parameter int NUM_CPU = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_CPU-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_CPU-1:0] pick,
    output logic               vld
);

    always_comb begin
        pick = '0;
        vld  = 1'b0;
        for (int i = 0; i < NUM_CPU; i++) begin
            if (!vld && req[(int'(ptr) + i) % NUM_CPU]) begin
                pick[(int'(ptr) + i) % NUM_CPU] = 1'b1;
                vld                             = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin arbiter granting one of NUM_CPU cores to a single external SRAM.
// Latency: strobes ACCESS_CYCLES cycles after grant, memReady one cycle later.
// Backpressure: ungranted cores see memReady low and hold. SRAM_ARB_STATS_EN adds grant counters.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NUM_CPU       = NUM_CPU_DEF,
    parameter int ADDR_W        = ADDR_W_DEF,
    parameter int DATA_W        = DATA_W_DEF,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic           Clk,
    input  logic           Reset,
    sram_arbiter_if.master bus
);

    localparam int PTR_W = (NUM_CPU > 1) ? $clog2(NUM_CPU) : 1;
    localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);

    arb_state_t         state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_CPU-1:0] grant_q, grant_d;
    logic [PTR_W-1:0]   gidx_q, gidx_d;
    logic               wr_q, wr_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               ce_q, ce_d;
    logic               oe_q, oe_d;
    logic               we_q, we_d;
    logic [NUM_CPU-1:0] mem_ready_q, mem_ready_d;

    logic [NUM_CPU-1:0] req_vec;
    logic [NUM_CPU-1:0] pick;
    logic               pick_vld;
    logic [PTR_W-1:0]   pick_idx;
    logic               pick_wr;

    assign req_vec = ~bus.cpu_CE;

    rr_pick #(
        .NUM_CPU (NUM_CPU),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .req  (req_vec),
        .ptr  (rr_ptr_q),
        .pick (pick),
        .vld  (pick_vld)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_CPU; i++) begin
            if (pick[i]) begin
                pick_idx = PTR_W'(i);
            end
        end
    end

    assign pick_wr = ~bus.cpu_WE[pick_idx];

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        cnt_d       = cnt_q;
        grant_d     = grant_q;
        gidx_d      = gidx_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        ce_d        = ce_q;
        oe_d        = oe_q;
        we_d        = we_q;
        mem_ready_d = '0;

        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d = ACCESS;
                    grant_d = pick;
                    gidx_d  = pick_idx;
                    wr_d    = pick_wr;
                    addr_d  = bus.cpu_ADDR[pick_idx*ADDR_W +: ADDR_W];
                    wdata_d = bus.cpu_wdata[pick_idx*DATA_W +: DATA_W];
                    cnt_d   = CNT_LOAD;
                    ce_d    = 1'b0;
                    oe_d    = pick_wr;
                    we_d    = ~pick_wr;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    state_d     = DONE;
                    ce_d        = 1'b1;
                    oe_d        = 1'b1;
                    we_d        = 1'b1;
                    mem_ready_d = grant_q;
                    if (!wr_q) begin
                        rdata_d = bus.Data_from_SRAM;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                state_d  = IDLE;
                grant_d  = '0;
                rr_ptr_d = (gidx_q == PTR_W'(NUM_CPU - 1)) ? '0 : gidx_q + PTR_W'(1);
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reset drops strobes and pending memReady at once, aborting any access.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            cnt_q       <= '0;
            grant_q     <= '0;
            gidx_q      <= '0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            ce_q        <= 1'b1;
            oe_q        <= 1'b1;
            we_q        <= 1'b1;
            mem_ready_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            cnt_q       <= cnt_d;
            grant_q     <= grant_d;
            gidx_q      <= gidx_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            ce_q        <= ce_d;
            oe_q        <= oe_d;
            we_q        <= we_d;
            mem_ready_q <= mem_ready_d;
        end
    end

    assign bus.CE                 = ce_q;
    assign bus.UB                 = ce_q;
    assign bus.LB                 = ce_q;
    assign bus.OE                 = oe_q;
    assign bus.WE                 = we_q;
    assign bus.ADDR               = addr_q;
    assign bus.Data_to_SRAM       = wdata_q;
    assign bus.Data_from_SRAM_cpu = rdata_q;
    assign bus.grant              = grant_q;
    assign bus.memReady           = mem_ready_q;

`ifdef SRAM_ARB_STATS_EN
    logic [NUM_CPU-1:0][15:0] stat_q, stat_d;
    logic                     enter_done;

    assign enter_done = (state_q == ACCESS) && (cnt_q == '0);

    always_comb begin
        stat_d = stat_q;
        for (int i = 0; i < NUM_CPU; i++) begin
            if (enter_done && grant_q[i] && (stat_q[i] != 16'hFFFF)) begin
                stat_d[i] = stat_q[i] + 16'd1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            stat_q <= '0;
        end else begin
            stat_q <= stat_d;
        end
    end

    assign bus.grant_count = stat_q;
`else
    assign bus.grant_count = '0;
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: reset, read, write, contention, fairness, abort, stats.
module tb_sram_arbiter;

    localparam int N  = 4;
    localparam int AW = 20;
    localparam int DW = 16;
    localparam int AC = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    sram_arbiter_if #(.NUM_CPU(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    sram_arbiter #(
        .NUM_CPU       (N),
        .ADDR_W        (AW),
        .DATA_W        (DW),
        .ACCESS_CYCLES (AC)
    ) dut (
        .Clk   (clk),
        .Reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    task automatic set_req(input int c, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.cpu_CE[c]            = 1'b0;
        bus.cpu_WE[c]            = ~wr;
        bus.cpu_ADDR[c*AW +: AW] = a;
        bus.cpu_wdata[c*DW +: DW] = d;
    endtask

    task automatic do_reset();
        rst_n              = 1'b0;
        bus.cpu_CE         = '1;
        bus.cpu_WE         = '1;
        bus.cpu_ADDR       = '0;
        bus.cpu_wdata      = '0;
        bus.Data_from_SRAM = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Waits for core c's memReady, then releases its request within that cycle.
    task automatic wait_ready(input int c, input string name);
        bit seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (bus.memReady[c]) begin
                seen          = 1'b1;
                bus.cpu_CE[c] = 1'b1;
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s memReady[%0d] timeout got=0 exp=1", name, c);
        end
    endtask

    task automatic test_reset();
        bus.cpu_CE = '1; bus.cpu_WE = '1; bus.cpu_ADDR = '0; bus.cpu_wdata = '0;
        bus.Data_from_SRAM = '0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.CE, bus.UB, bus.LB, bus.OE, bus.WE} !== 5'b11111) begin
            failures++;
            $display("FAIL reset_strobes got=%b exp=11111", {bus.CE, bus.UB, bus.LB, bus.OE, bus.WE});
        end
        checks++;
        if ({bus.ADDR, bus.Data_to_SRAM, bus.Data_from_SRAM_cpu} !== '0) begin
            failures++;
            $display("FAIL reset_data addr=%h wdata=%h rdata=%h exp=0", bus.ADDR, bus.Data_to_SRAM, bus.Data_from_SRAM_cpu);
        end
        checks++;
        if ({bus.grant, bus.memReady} !== 8'h00 || bus.grant_count !== '0) begin
            failures++;
            $display("FAIL reset_ctrl grant=%b ready=%b count=%h exp=0", bus.grant, bus.memReady, bus.grant_count);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_read();
        @(posedge clk); #1;
        bus.Data_from_SRAM = 16'hBEEF;
        set_req(2, 1'b0, 20'h00123, 16'h0000);
        @(negedge clk);
        checks++;
        if (bus.grant !== 4'b0000) begin
            failures++; $display("FAIL read_idle_grant got=%b exp=0000", bus.grant);
        end
        for (int k = 1; k <= AC; k++) begin
            @(negedge clk);
            checks++;
            if ({bus.CE, bus.UB, bus.LB, bus.OE, bus.WE} !== 5'b00001 || bus.ADDR !== 20'h00123 ||
                bus.grant !== 4'b0100 || bus.memReady !== 4'b0000) begin
                failures++;
                $display("FAIL read_access%0d strobes=%b addr=%h grant=%b ready=%b exp=00001/00123/0100/0000",
                         k, {bus.CE, bus.UB, bus.LB, bus.OE, bus.WE}, bus.ADDR, bus.grant, bus.memReady);
            end
        end
        @(negedge clk);
        checks++;
        if (bus.memReady !== 4'b0100 || bus.Data_from_SRAM_cpu !== 16'hBEEF ||
            {bus.CE, bus.UB, bus.LB, bus.OE, bus.WE} !== 5'b11111) begin
            failures++;
            $display("FAIL read_done ready=%b rdata=%h strobes=%b exp=0100/beef/11111",
                     bus.memReady, bus.Data_from_SRAM_cpu, {bus.CE, bus.UB, bus.LB, bus.OE, bus.WE});
        end
        bus.cpu_CE[2] = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.grant !== 4'b0000 || bus.memReady !== 4'b0000 || bus.ADDR !== 20'h00123) begin
            failures++;
            $display("FAIL read_after grant=%b ready=%b addr=%h exp=0000/0000/00123", bus.grant, bus.memReady, bus.ADDR);
        end
    endtask

    task automatic test_single_write();
        @(posedge clk); #1;
        bus.Data_from_SRAM = 16'hDEAD;
        set_req(0, 1'b1, 20'h00010, 16'h1234);
        @(negedge clk);
        for (int k = 1; k <= AC; k++) begin
            @(negedge clk);
            checks++;
            if ({bus.CE, bus.UB, bus.LB, bus.OE, bus.WE} !== 5'b00010 || bus.ADDR !== 20'h00010 ||
                bus.Data_to_SRAM !== 16'h1234 || bus.grant !== 4'b0001) begin
                failures++;
                $display("FAIL write_access%0d strobes=%b addr=%h wdata=%h grant=%b exp=00010/00010/1234/0001",
                         k, {bus.CE, bus.UB, bus.LB, bus.OE, bus.WE}, bus.ADDR, bus.Data_to_SRAM, bus.grant);
            end
            bus.cpu_ADDR[0 +: AW]  = 20'h99999;
            bus.cpu_wdata[0 +: DW] = 16'h5555;
        end
        @(negedge clk);
        checks++;
        if (bus.memReady !== 4'b0001 || bus.Data_from_SRAM_cpu !== 16'hBEEF) begin
            failures++;
            $display("FAIL write_done ready=%b rdata=%h exp=0001/beef", bus.memReady, bus.Data_from_SRAM_cpu);
        end
        bus.cpu_CE[0] = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.Data_to_SRAM !== 16'h1234 || bus.Data_from_SRAM_cpu !== 16'hBEEF) begin
            failures++;
            $display("FAIL write_hold wdata=%h rdata=%h exp=1234/beef", bus.Data_to_SRAM, bus.Data_from_SRAM_cpu);
        end
    endtask

    task automatic test_contention();
        do_reset();
        @(posedge clk); #1;
        for (int c = 0; c < N; c++) set_req(c, 1'b0, AW'(c), '0);
        @(negedge clk);
        for (int cyc = 1; cyc <= 16; cyc++) begin
            int            k;
            int            ph;
            logic [N-1:0]  exp_rdy;
            logic          exp_ce;
            @(negedge clk);
            k       = (cyc - 1) / 4;
            ph      = (cyc - 1) % 4;
            exp_rdy = (ph == 2) ? N'(1 << k) : '0;
            exp_ce  = (ph >= 2);
            checks++;
            if (bus.memReady !== exp_rdy || bus.CE !== exp_ce) begin
                failures++;
                $display("FAIL contention_c%0d ready=%b CE=%b exp=%b/%b", cyc, bus.memReady, bus.CE, exp_rdy, exp_ce);
            end
            if (ph != 2) begin
                checks++;
                if (bus.grant !== ((ph == 3) ? 4'b0000 : N'(1 << k))) begin
                    failures++;
                    $display("FAIL contention_grant_c%0d got=%b exp=%b", cyc, bus.grant, (ph == 3) ? 4'b0000 : N'(1 << k));
                end
            end
            if (ph == 2) bus.cpu_CE[k] = 1'b1;
        end
    endtask

    task automatic test_fairness();
        logic [N-1:0] got [3];
        int           n = 0;
        @(posedge clk); #1;
        set_req(0, 1'b0, 20'h00001, '0);
        wait_ready(0, "fair_setup");
        @(posedge clk); #1;
        set_req(1, 1'b0, 20'h00011, '0);
        set_req(3, 1'b0, 20'h00033, '0);
        for (int k = 0; k < 40 && n < 3; k++) begin
            @(negedge clk);
            if (bus.memReady != '0) begin
                got[n] = bus.memReady;
                if (bus.memReady[3]) bus.cpu_CE[3] = 1'b1;
                if (n == 2) bus.cpu_CE[1] = 1'b1;
                n++;
            end
        end
        checks++;
        if (n != 3) begin
            failures++; $display("FAIL fair_count got=%0d exp=3", n);
        end else begin
            checks++;
            if (got[0] !== 4'b0010 || got[1] !== 4'b1000 || got[2] !== 4'b0010) begin
                failures++;
                $display("FAIL fair_order got=%b,%b,%b exp=0010,1000,0010", got[0], got[1], got[2]);
            end
        end
        bus.cpu_CE = '1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        do_reset();
        @(posedge clk); #1;
        set_req(1, 1'b0, 20'h00101, '0);
        wait_ready(1, "abort_setup");
        @(posedge clk); #1;
        set_req(2, 1'b0, 20'h00202, '0);
        set_req(0, 1'b0, 20'h00404, '0);
        @(posedge clk);
        @(posedge clk); #2;
        checks++;
        if (bus.CE !== 1'b0 || bus.grant !== 4'b0100) begin
            failures++; $display("FAIL abort_pre CE=%b grant=%b exp=0/0100", bus.CE, bus.grant);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.CE, bus.UB, bus.LB, bus.OE, bus.WE} !== 5'b11111 || bus.grant !== 4'b0000 || bus.memReady !== 4'b0000) begin
            failures++;
            $display("FAIL abort_now strobes=%b grant=%b ready=%b exp=11111/0000/0000",
                     {bus.CE, bus.UB, bus.LB, bus.OE, bus.WE}, bus.grant, bus.memReady);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.grant !== 4'b0001 || bus.memReady !== 4'b0000 || bus.ADDR !== 20'h00404) begin
            failures++;
            $display("FAIL abort_regrant grant=%b ready=%b addr=%h exp=0001/0000/00404", bus.grant, bus.memReady, bus.ADDR);
        end
        wait_ready(0, "abort_core0");
        bus.cpu_CE = '1;
        @(negedge clk);
    endtask

    task automatic test_stats();
        logic [15:0] exp3;
`ifdef SRAM_ARB_STATS_EN
        exp3 = 16'd5;
`else
        exp3 = 16'd0;
`endif
        do_reset();
        for (int r = 0; r < 5; r++) begin
            @(posedge clk); #1;
            set_req(3, 1'b0, AW'(r), '0);
            wait_ready(3, "stats_access");
        end
        @(negedge clk);
        for (int c = 0; c < N; c++) begin
            checks++;
            if (bus.grant_count[c*16 +: 16] !== ((c == 3) ? exp3 : 16'd0)) begin
                failures++;
                $display("FAIL stats_count%0d got=%0d exp=%0d", c, bus.grant_count[c*16 +: 16], (c == 3) ? exp3 : 16'd0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_single_write();
        test_contention();
        test_fairness();
        test_reset_mid();
        test_stats();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
